// File: rtl/shift_pipe.sv
// shift_pipe: enable-gated delay line of DEPTH stages with per-stage valid
// tracking, a saturating fill counter and a runtime-selectable tap.
// mode 0 shifts one stage per enabled edge; mode 1 loads din into every stage.
module shift_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAP_W  = 2,
    parameter int unsigned FILL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [WIDTH-1:0]  din,
    input  logic [TAP_W-1:0]  tap_sel,
    output logic [WIDTH-1:0]  dout,
    output logic [WIDTH-1:0]  tap_out,
    output logic [DEPTH-1:0]  valid,
    output logic [FILL_W-1:0] fill,
    output logic              full
);

    localparam logic [FILL_W-1:0] FillMax = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              full_q, full_d;

    // Next state: hold when disabled, shift in mode 0, broadcast in mode 1.
    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        fill_d  = fill_q;
        if (en) begin
            if (mode) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_d[i] = din;
                end
                valid_d = '1;
                fill_d  = FillMax;
            end else begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
                // Valid bits stay a thermometer code growing from bit 0.
                valid_d = {valid_q[DEPTH-2:0], 1'b1};
                if (fill_q != FillMax) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
        full_d = (fill_d == FillMax);
    end

    // State registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
        end
    end

    // Tap mux; selects beyond the last stage (non-power-of-two DEPTH) read 0.
    always_comb begin
        tap_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_out = stage_q[i];
            end
        end
    end

    assign dout  = stage_q[DEPTH-1];
    assign valid = valid_q;
    assign fill  = fill_q;
    assign full  = full_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: a DEPTH=4 and a DEPTH=3 instance share stimulus.
// A queue-of-captures model is checked every cycle, plus literal expectations.
module tb_shift_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] tap_sel = 2'd0;

    logic [7:0] dout_a, tap_a;
    logic [3:0] valid_a;
    logic [2:0] fill_a;
    logic       full_a;
    logic [7:0] dout_b, tap_b;
    logic [2:0] valid_b;
    logic [1:0] fill_b;
    logic       full_b;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(8), .DEPTH(4), .TAP_W(2), .FILL_W(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .tap_sel(tap_sel),
        .dout(dout_a), .tap_out(tap_a), .valid(valid_a), .fill(fill_a), .full(full_a)
    );

    shift_pipe #(.WIDTH(8), .DEPTH(3), .TAP_W(2), .FILL_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .tap_sel(tap_sel),
        .dout(dout_b), .tap_out(tap_b), .valid(valid_b), .fill(fill_b), .full(full_b)
    );

    // Model: newest capture first; a broadcast counts as DEPTH captures of din.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else if (en) begin
            for (int k = 0; k < (mode ? 4 : 1); k++) qa.push_front(din);
            for (int k = 0; k < (mode ? 3 : 1); k++) qb.push_front(din);
            while (qa.size() > 4) void'(qa.pop_back());
            while (qb.size() > 3) void'(qb.pop_back());
        end
    end

    function automatic logic [7:0] stage_a(int i);
        return (i < qa.size()) ? qa[i] : 8'h00;
    endfunction

    function automatic logic [7:0] stage_b(int i);
        return (i < 3 && i < qb.size()) ? qb[i] : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model mid-cycle, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_dout_a", 32'(dout_a), 32'(stage_a(3)));
            chk("m_tap_a", 32'(tap_a), 32'(stage_a(int'(tap_sel))));
            chk("m_valid_a", 32'(valid_a), (32'd1 << qa.size()) - 1);
            chk("m_fill_a", 32'(fill_a), 32'(qa.size()));
            chk("m_full_a", 32'(full_a), 32'(qa.size() == 4));
            chk("m_dout_b", 32'(dout_b), 32'(stage_b(2)));
            chk("m_tap_b", 32'(tap_b), 32'(stage_b(int'(tap_sel))));
            chk("m_valid_b", 32'(valid_b), (32'd1 << qb.size()) - 1);
            chk("m_fill_b", 32'(fill_b), 32'(qb.size()));
            chk("m_full_b", 32'(full_b), 32'(qb.size() == 3));
        end
    end

    task automatic step(input logic r, input logic e, input logic m, input logic [7:0] d);
        rst  = r;
        en   = e;
        mode = m;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_din  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_dout [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    logic [7:0] exp_doutb[5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    logic [2:0] exp_fill [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] exp_tap  [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_tapb [4] = '{8'h44, 8'h33, 8'h22, 8'h00};

    initial begin
        // Reset state.
        tap_sel = 2'd0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        cmp_en = 1'b1;
        chk("rst_dout", 32'(dout_a), 32'h0);
        chk("rst_tap", 32'(tap_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_fill", 32'(fill_a), 32'h0);
        chk("rst_full", 32'(full_a), 32'h0);

        // Mode 0 fill; tap sweep with en=0 inserted after the fourth edge.
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                for (int t = 0; t < 4; t++) begin
                    tap_sel = 2'(t);
                    #1;
                    chk("sweep_tap_a", 32'(tap_a), 32'(exp_tap[t]));
                    chk("sweep_tap_b", 32'(tap_b), 32'(exp_tapb[t]));
                    step(1'b0, 1'b0, 1'b0, 8'hEE);
                end
                tap_sel = 2'd0;
            end
            step(1'b0, 1'b1, 1'b0, seq_din[k]);
            chk("fill_dout_a", 32'(dout_a), 32'(exp_dout[k]));
            chk("fill_dout_b", 32'(dout_b), 32'(exp_doutb[k]));
            chk("fill_cnt_a", 32'(fill_a), 32'(exp_fill[k]));
            chk("fill_full_a", 32'(full_a), 32'(k >= 3));
        end

        // Mid-fill reset with en=1 and din=FF.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        chk("midrst_valid", 32'(valid_a), 32'h0);
        chk("midrst_fill", 32'(fill_a), 32'h0);
        chk("midrst_full", 32'(full_a), 32'h0);
        chk("midrst_tap0", 32'(tap_a), 32'h0);
        chk("midrst_dout", 32'(dout_a), 32'h0);

        // Broadcast from reset.
        step(1'b0, 1'b1, 1'b1, 8'hA5);
        chk("bc_valid_a", 32'(valid_a), 32'hF);
        chk("bc_fill_a", 32'(fill_a), 32'd4);
        chk("bc_full_a", 32'(full_a), 32'd1);
        chk("bc_dout_a", 32'(dout_a), 32'hA5);
        chk("bc_valid_b", 32'(valid_b), 32'h7);
        chk("bc_fill_b", 32'(fill_b), 32'd3);
        en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t);
            #1;
            chk("bc_tap_a", 32'(tap_a), 32'hA5);
        end
        tap_sel = 2'd0;

        // Enable gap: 0x01 needs exactly four enabled edges to reach dout.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE);
            chk("gap_tap0", 32'(tap_a), 32'h01);
            chk("gap_fill", 32'(fill_a), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 8'h02);
        chk("gap_dout2", 32'(dout_a), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h03);
        chk("gap_dout3", 32'(dout_a), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h04);
        chk("gap_dout4", 32'(dout_a), 32'h01);

        // Reset wins over a broadcast on the same edge.
        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("rst_bc_fill", 32'(fill_a), 32'h0);
        chk("rst_bc_dout", 32'(dout_a), 32'h0);

        // Mixed traffic, checked against the model only.
        for (int k = 0; k < 60; k++) begin
            tap_sel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0), 8'($urandom));
        end

        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
